stream_keystream_core: RTL and testbench
========================================

# stream_keystream_core

Parametrised stream-cipher engine: three nonlinear feedback shift registers generate DATA_W keystream bits per clock. Each accepted input word is XORed with the keystream and presented on a valid/ready output stage. This generation adds runtime key/IV loading, a warm-up phase, handshaked backpressure and a word counter. It sits between the pad-level byte interface and the data consumer.

## Interface
- DATA_W, 8: data/keystream word width; cipher steps per cycle (1..16)
- REG_W, 64: width of each shift register A, B, C (>= 24)
- KEY_W, 32: key and IV width (<= REG_W)
- WARMUP, 16: cycles of discarded stepping after a load (>= 1)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- init  in  1  load pulse; samples key_in and iv_in
- key_in  in  KEY_W  key
- iv_in  in  KEY_W  initialisation vector
- s_valid  in  1  input word valid
- s_ready  out  1  core accepts the input word this cycle
- s_data  in  DATA_W  plaintext or ciphertext
- m_valid  out  1  output word valid
- m_ready  in  1  consumer accepts the output word
- m_data  out  DATA_W  s_data XOR keystream
- busy  out  1  high in WARM
- word_cnt  out  32  words processed since the last load; saturates at 0xFFFF_FFFF

## Operation
- One cipher step, all terms from the pre-step values:
  - z = A[REG_W-1]^B[REG_W-1]^C[REG_W-1]
  - fa = C[REG_W-1]^C[5]^(C[2]&C[3])^A[9]
  - fb = A[REG_W-1]^A[7]^(A[4]&A[5])^B[11]
  - fc = B[REG_W-1]^B[13]^(B[1]&B[6])^C[17]
  - A <= {A[REG_W-2:0],fa}; B <= {B[REG_W-2:0],fb}; C <= {C[REG_W-2:0],fc}
- Keystream word: DATA_W steps unrolled in one cycle. The first step's z goes to the word's MSB and the last step's z to its LSB.
- Load: A = zero-extended key_in, B = zero-extended iv_in, C = all ones. word_cnt = 0, m_valid = 0.
- States:
  - IDLE: reached after reset; registers hold. s_ready = 0.
  - WARM: one keystream word per cycle is generated and discarded, for WARMUP cycles. Then the block moves to RUN.
  - RUN: s_ready = !m_valid | m_ready. On s_valid & s_ready: m_data <= s_data ^ ks, m_valid <= 1, the registers advance one word, and word_cnt increments (saturating). Otherwise the registers hold.
  - Pending output: m_valid clears on m_ready when no new word is accepted.
- init in any state performs the load and enters WARM; a pending output word is dropped. init has priority over a simultaneous s_valid handshake.
- The keystream advances only on accepted words, so a stalled consumer never skips keystream.
- Encryption and decryption are the same operation.

## Timing
- Reset values: s_ready 0, m_valid 0, m_data 0, busy 0, word_cnt 0; A, B, C all zero; state IDLE.
- init sampled at edge T: busy = 1 from T+1 through T+WARMUP; s_ready can first be 1 at T+WARMUP+1.
- Latency: an input accepted at edge T appears on m_data/m_valid at T+1.
- Throughput: one word per clock with m_ready held high.
- m_data and m_valid stay stable while m_valid=1 and m_ready=0.
- Reset asserted mid-stream clears everything asynchronously; output words after reset require a new init.

## Test plan
- Reset, then no init with s_valid=1 -> s_ready stays 0, m_valid 0, word_cnt 0 for 100 cycles.
- init with key=0x0123_4567, iv=0x89AB_CDEF, WARMUP=16 -> busy high exactly 16 cycles, first s_ready at cycle 17; 64 zero words in -> m_data matches a bit-exact reference model of the step equations; word_cnt=64.
- Round trip: encrypt 256 random words, re-init with the same key/IV, decrypt -> the original words are recovered exactly.
- Backpressure: m_ready toggled randomly at 50% -> no word lost or duplicated, m_data stable while stalled, output equals the m_ready=1 run.
- init in RUN with a pending m_valid, and init together with s_valid -> output dropped, WARM re-entered, stream equals a fresh load.
- Async reset mid-burst, then reload -> all outputs zero during reset; the stream after reload matches the fresh-load stream; word_cnt restarts at 0.

Source files
------------

// File: rtl/stream_keystream_core.sv
// Three-NLFSR stream cipher: DATA_W keystream bits per clock XORed onto a valid/ready stream.
// The keystream advances only on accepted words, so a stalled consumer never skips keystream.
module stream_keystream_core #(
  parameter int DATA_W = 8,
  parameter int REG_W  = 64,
  parameter int KEY_W  = 32,
  parameter int WARMUP = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic [KEY_W-1:0]  key_in,
  input  logic [KEY_W-1:0]  iv_in,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              busy,
  output logic [31:0]       word_cnt
);

  // state | meaning
  // IDLE  | after reset, no key loaded; registers hold, input refused
  // WARM  | stepping WARMUP keystream words after a load, output discarded
  // RUN   | one keystream word consumed per accepted input word
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WARM = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam int CNT_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    warm_q, warm_d;
  logic [REG_W-1:0]    a_q, a_d, b_q, b_d, c_q, c_d;
  logic                m_valid_q, m_valid_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic [31:0]         cnt_q, cnt_d;

  logic [REG_W-1:0]    step_a, step_b, step_c;
  logic [DATA_W-1:0]   ks;
  logic                z, fa, fb, fc;
  logic                accept;

  // DATA_W unrolled steps; the first step's output lands in the word's MSB.
  always_comb begin
    step_a = a_q;
    step_b = b_q;
    step_c = c_q;
    ks     = '0;
    z      = 1'b0;
    fa     = 1'b0;
    fb     = 1'b0;
    fc     = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      z  = step_a[REG_W-1] ^ step_b[REG_W-1] ^ step_c[REG_W-1];
      fa = step_c[REG_W-1] ^ step_c[5]  ^ (step_c[2] & step_c[3]) ^ step_a[9];
      fb = step_a[REG_W-1] ^ step_a[7]  ^ (step_a[4] & step_a[5]) ^ step_b[11];
      fc = step_b[REG_W-1] ^ step_b[13] ^ (step_b[1] & step_b[6]) ^ step_c[17];
      step_a = {step_a[REG_W-2:0], fa};
      step_b = {step_b[REG_W-2:0], fb};
      step_c = {step_c[REG_W-2:0], fc};
      ks[DATA_W-1-i] = z;
    end
  end

  assign s_ready = (state_q == S_RUN) && (!m_valid_q || m_ready);
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_d   = state_q;
    warm_d    = warm_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    cnt_d     = cnt_q;
    if (init) begin
      // init wins over a same-cycle handshake; any pending word is dropped
      a_d       = REG_W'(key_in);
      b_d       = REG_W'(iv_in);
      c_d       = '1;
      state_d   = S_WARM;
      warm_d    = CNT_W'(WARMUP - 1);
      m_valid_d = 1'b0;
      cnt_d     = '0;
    end else begin
      case (state_q)
        S_WARM: begin
          a_d = step_a;
          b_d = step_b;
          c_d = step_c;
          if (warm_q == '0) state_d = S_RUN;
          else              warm_d  = warm_q - 1'b1;
        end
        S_RUN: begin
          if (accept) begin
            a_d       = step_a;
            b_d       = step_b;
            c_d       = step_c;
            m_data_d  = s_data ^ ks;
            m_valid_d = 1'b1;
            if (cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
          end else if (m_ready) begin
            m_valid_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      warm_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      warm_q    <= warm_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign busy     = (state_q == S_WARM);
  assign word_cnt = cnt_q;

endmodule

// File: tb/tb_stream_keystream_core.sv
// Bench for stream_keystream_core: random traffic checked against a bit-array cipher model.
module tb_stream_keystream_core;
  localparam int DATA_W = 8;
  localparam int REG_W  = 64;
  localparam int KEY_W  = 32;
  localparam int WARMUP = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              init = 1'b0;
  logic [KEY_W-1:0]  key_in = '0;
  logic [KEY_W-1:0]  iv_in = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic [DATA_W-1:0] m_data;
  logic              busy;
  logic [31:0]       word_cnt;

  int checks = 0;
  int passed = 0;
  int cnt_since_load = 0;

  bit ra[REG_W];
  bit rb[REG_W];
  bit rc[REG_W];

  logic [DATA_W-1:0] in_q[$];
  logic [DATA_W-1:0] out_q[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] save_q[$];

  stream_keystream_core #(
    .DATA_W(DATA_W), .REG_W(REG_W), .KEY_W(KEY_W), .WARMUP(WARMUP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .init(init), .key_in(key_in), .iv_in(iv_in),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  // one cipher step on the model registers; returns the output bit
  function automatic bit ref_step();
    bit z, fa, fb, fc;
    z  = ra[REG_W-1] ^ rb[REG_W-1] ^ rc[REG_W-1];
    fa = rc[REG_W-1] ^ rc[5]  ^ (rc[2] & rc[3]) ^ ra[9];
    fb = ra[REG_W-1] ^ ra[7]  ^ (ra[4] & ra[5]) ^ rb[11];
    fc = rb[REG_W-1] ^ rb[13] ^ (rb[1] & rb[6]) ^ rc[17];
    for (int k = REG_W - 1; k > 0; k--) begin
      ra[k] = ra[k-1];
      rb[k] = rb[k-1];
      rc[k] = rc[k-1];
    end
    ra[0] = fa;
    rb[0] = fb;
    rc[0] = fc;
    return z;
  endfunction

  function automatic logic [DATA_W-1:0] ref_word();
    logic [DATA_W-1:0] w;
    w = '0;
    for (int i = 0; i < DATA_W; i++) w = {w[DATA_W-2:0], ref_step()};
    return w;
  endfunction

  function automatic void ref_load(input logic [KEY_W-1:0] k, input logic [KEY_W-1:0] v);
    logic [DATA_W-1:0] discard;
    for (int i = 0; i < REG_W; i++) begin
      ra[i] = (i < KEY_W) ? k[i] : 1'b0;
      rb[i] = (i < KEY_W) ? v[i] : 1'b0;
      rc[i] = 1'b1;
    end
    for (int i = 0; i < WARMUP; i++) discard = ref_word();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init(input logic [KEY_W-1:0] k, input logic [KEY_W-1:0] v);
    init   = 1'b1;
    key_in = k;
    iv_in  = v;
    tick();
    init = 1'b0;
    ref_load(k, v);
    cnt_since_load = 0;
  endtask

  // feeds in_q[0..n-1] with random gaps; m_ready high with probability pct%
  task automatic run_words(input int n, input int pct);
    int idx = 0;
    int got = 0;
    int cyc = 0;
    bit prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    logic [DATA_W-1:0] e;
    logic hin, hout;
    out_q.delete();
    exp_q.delete();
    while ((idx < n || got < n) && cyc < 40 * n + 200) begin
      if (prev_stall) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== prev_data)
          $display("FAIL stall_hold: m_valid=%b m_data=%h, required 1 / %h", m_valid, m_data, prev_data);
        else passed++;
      end
      m_ready = ($urandom_range(99) < pct);
      s_valid = (idx < n) && ($urandom_range(3) != 0);
      s_data  = (idx < n) ? in_q[idx] : '0;
      #1;
      hin  = s_valid & s_ready;
      hout = m_valid & m_ready;
      if (hout) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL extra_word: m_data=%h delivered, required no word", m_data);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e) $display("FAIL word_data[%0d]: m_data=%h, required %h", got, m_data, e);
          else passed++;
        end
        out_q.push_back(m_data);
        got++;
      end
      if (hin) begin
        exp_q.push_back(s_data ^ ref_word());
        idx++;
        cnt_since_load++;
      end
      prev_stall = m_valid & ~m_ready;
      prev_data  = m_data;
      @(posedge clk);
      #1;
      cyc++;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    checks++;
    if (got != n) $display("FAIL stream_count: got %0d words, required %0d", got, n);
    else passed++;
    checks++;
    if (word_cnt !== 32'(cnt_since_load))
      $display("FAIL word_cnt: word_cnt=%0d, required %0d", word_cnt, cnt_since_load);
    else passed++;
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_data !== '0 || busy !== 1'b0 || word_cnt !== '0)
      $display("FAIL %s: s_ready=%b m_valid=%b m_data=%h busy=%b word_cnt=%0d, required all 0",
               name, s_ready, m_valid, m_data, busy, word_cnt);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    check_all_zero("reset_values");
    tick();
    rst_n = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'hA5;
    for (int c = 0; c < 100; c++) begin
      tick();
      checks++;
      if (s_ready !== 1'b0 || m_valid !== 1'b0 || word_cnt !== '0)
        $display("FAIL idle_no_init c%0d: s_ready=%b m_valid=%b word_cnt=%0d, required 0/0/0",
                 c, s_ready, m_valid, word_cnt);
      else passed++;
    end
    s_valid = 1'b0;
  endtask

  task automatic test_warmup_and_zero_stream();
    int busy_cycles = 0;
    int first_ready = 0;
    do_init(32'h0123_4567, 32'h89AB_CDEF);
    for (int c = 1; c <= 40; c++) begin
      if (busy === 1'b1) busy_cycles++;
      if (s_ready === 1'b1 && first_ready == 0) first_ready = c;
      tick();
    end
    checks++;
    if (busy_cycles != WARMUP) $display("FAIL busy_len: busy for %0d cycles, required %0d", busy_cycles, WARMUP);
    else passed++;
    checks++;
    if (first_ready != WARMUP + 1) $display("FAIL first_ready: cycle %0d, required %0d", first_ready, WARMUP + 1);
    else passed++;
    in_q.delete();
    for (int i = 0; i < 64; i++) in_q.push_back('0);
    run_words(64, 100);
  endtask

  task automatic test_round_trip();
    logic [KEY_W-1:0] k, v;
    int bad = 0;
    k = $urandom;
    v = $urandom;
    in_q.delete();
    for (int i = 0; i < 256; i++) in_q.push_back(DATA_W'($urandom));
    save_q = in_q;
    do_init(k, v);
    run_words(256, 100);
    in_q = out_q;
    do_init(k, v);
    run_words(256, 70);
    for (int i = 0; i < 256; i++) if (out_q.size() <= i || out_q[i] !== save_q[i]) bad++;
    checks++;
    if (bad != 0) $display("FAIL round_trip: %0d words differ from plaintext, required 0", bad);
    else passed++;
  endtask

  task automatic test_back_to_back_backpressure();
    logic [KEY_W-1:0] k, v;
    int bad = 0;
    k = $urandom;
    v = $urandom;
    in_q.delete();
    for (int i = 0; i < 64; i++) in_q.push_back(DATA_W'($urandom));
    do_init(k, v);
    run_words(64, 100);
    save_q = out_q;
    do_init(k, v);
    run_words(64, 50);
    for (int i = 0; i < 64; i++) if (out_q.size() <= i || out_q[i] !== save_q[i]) bad++;
    checks++;
    if (bad != 0) $display("FAIL backpressure_equal: %0d words differ from ready-high run, required 0", bad);
    else passed++;
  endtask

  task automatic test_init_in_run();
    do_init(32'hDEAD_BEEF, 32'h1357_9BDF);
    repeat (WARMUP) tick();
    s_valid = 1'b1;
    s_data  = 8'h3C;
    m_ready = 1'b0;
    tick();
    s_valid = 1'b0;
    checks++;
    if (m_valid !== 1'b1) $display("FAIL pending_word: m_valid=%b, required 1", m_valid);
    else passed++;
    init    = 1'b1;
    s_valid = 1'b1;
    m_ready = 1'b1;
    tick();
    init    = 1'b0;
    s_valid = 1'b0;
    ref_load(32'hDEAD_BEEF, 32'h1357_9BDF);
    cnt_since_load = 0;
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b1 || word_cnt !== '0)
      $display("FAIL init_drop: m_valid=%b busy=%b word_cnt=%0d, required 0/1/0", m_valid, busy, word_cnt);
    else passed++;
    in_q.delete();
    for (int i = 0; i < 16; i++) in_q.push_back('0);
    run_words(16, 100);
  endtask

  task automatic test_async_reset();
    do_init(32'hCAFE_F00D, 32'h0BAD_C0DE);
    repeat (WARMUP) tick();
    s_valid = 1'b1;
    s_data  = 8'h77;
    m_ready = 1'b1;
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    s_valid = 1'b0;
    tick();
    check_all_zero("reset_held");
    rst_n   = 1'b1;
    s_valid = 1'b1;
    repeat (4) tick();
    checks++;
    if (s_ready !== 1'b0 || m_valid !== 1'b0)
      $display("FAIL post_reset_idle: s_ready=%b m_valid=%b, required 0/0", s_ready, m_valid);
    else passed++;
    s_valid = 1'b0;
    do_init(32'hCAFE_F00D, 32'h0BAD_C0DE);
    checks++;
    if (word_cnt !== '0) $display("FAIL cnt_restart: word_cnt=%0d, required 0", word_cnt);
    else passed++;
    in_q.delete();
    for (int i = 0; i < 32; i++) in_q.push_back(DATA_W'($urandom));
    run_words(32, 60);
  endtask

  initial begin
    test_reset();
    test_warmup_and_zero_stream();
    test_round_trip();
    test_back_to_back_backpressure();
    test_init_in_run();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
